serial_word_queue: RTL and testbench

//  Parametrised serial-in/word-out queue: assembles WORD_W bits strobed on write_in into words,

---
 rtl/serial_word_queue_pkg.sv | 17 +
 rtl/serial_word_queue_if.sv | 30 +++
 rtl/serial_word_queue_fifo.sv | 74 +++++++
 rtl/serial_word_queue.sv | 120 ++++++++++++
 tb/tb_serial_word_queue.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_word_queue_pkg.sv
// rtl/serial_word_queue_pkg.sv - shared constants, bit-order enum and pointer-width helper
package serial_queue_pkg;

    localparam int DEF_WORD_W = 8;
    localparam int DEF_DEPTH  = 8;

    typedef enum logic {
        BIT_LSB_FIRST = 1'b0,
        BIT_MSB_FIRST = 1'b1
    } bit_order_e;

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/serial_word_queue_if.sv
// rtl/serial_word_queue_if.sv - serial-in/word-out queue signal bundle
// Inputs from the master : data_in, write_in, enqueue_in, dequeue_in, clear_in
// Outputs from the slave : data_out, status_out, empty_out, count_out, overflow_out
interface serial_word_queue_if
    import serial_queue_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int DEPTH  = DEF_DEPTH
);
    logic                       data_in;
    logic                       write_in;
    logic                       enqueue_in;
    logic                       dequeue_in;
    logic                       clear_in;
    logic [WORD_W-1:0]          data_out;
    logic                       status_out;
    logic                       empty_out;
    logic [$clog2(DEPTH+1)-1:0] count_out;
    logic                       overflow_out;

    modport master (
        output data_in, write_in, enqueue_in, dequeue_in, clear_in,
        input  data_out, status_out, empty_out, count_out, overflow_out
    );

    modport slave (
        input  data_in, write_in, enqueue_in, dequeue_in, clear_in,
        output data_out, status_out, empty_out, count_out, overflow_out
    );
endinterface

// File: rtl/serial_word_queue_fifo.sv
// rtl/serial_word_queue_fifo.sv - word_fifo: DEPTH-entry word store with registered pop output
// Ports: clk, rst_n (async active-low), i_push, i_pop, i_clear (sync, overrides push/pop),
//        i_wdata, o_rdata (last popped word), o_count, o_full, o_empty
module word_fifo
    import serial_queue_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_clear,
    input  logic [WORD_W-1:0]          i_wdata,
    output logic [WORD_W-1:0]          o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [WORD_W-1:0] r_rdata;

    logic w_do_pop;
    logic w_do_push;

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    // A pop on an empty store is a no-op; a push into a full store only
    // succeeds when a pop frees a slot on the same edge.
    assign w_do_pop  = i_pop & ~o_empty & ~i_clear;
    assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_clear;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rdata  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_rdata  <= r_mem[r_rd_ptr];
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign o_rdata = r_rdata;
    assign o_count = r_count;
endmodule

// File: rtl/serial_word_queue.sv
// rtl/serial_word_queue.sv - serial bit assembler feeding a word FIFO with overflow flag
// Ports: clock_1MHz, rst (async active-low), bus (serial_word_queue_if.slave):
//        serial bits in on write_in presses, pushes (auto or enqueue_in), pops on
//        dequeue_in presses, clear_in sync clear; data_out/status/empty/count/overflow out.
module serial_word_queue
    import serial_queue_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit AUTO_ENQ  = 1'b1
) (
    input  logic                 clock_1MHz,
    input  logic                 rst,
    serial_word_queue_if.slave   bus
);
    localparam bit_order_e ORDER = MSB_FIRST ? BIT_MSB_FIRST : BIT_LSB_FIRST;
    localparam int         BCW   = $clog2(WORD_W);
    localparam int         CW    = $clog2(DEPTH + 1);

    logic              r_write_q;
    logic              r_enq_q;
    logic              r_deq_q;
    logic [WORD_W-1:0] r_sr;
    logic [BCW-1:0]    r_bit_cnt;
    logic [WORD_W-1:0] r_hold;
    logic              r_pending;
    logic              r_overflow;

    logic              w_write_press;
    logic              w_enq_press;
    logic              w_deq_press;
    logic [WORD_W-1:0] w_shift_next;
    logic              w_last_bit;
    logic              w_push_req;
    logic              w_drop;
    logic              w_full;
    logic              w_empty;
    logic [WORD_W-1:0] w_rdata;
    logic [CW-1:0]     w_count;

    assign w_write_press = bus.write_in   & ~r_write_q;
    assign w_enq_press   = bus.enqueue_in & ~r_enq_q;
    assign w_deq_press   = bus.dequeue_in & ~r_deq_q;

    assign w_shift_next = (ORDER == BIT_MSB_FIRST) ? {r_sr[WORD_W-2:0], bus.data_in}
                                                   : {bus.data_in, r_sr[WORD_W-1:1]};
    assign w_last_bit   = (r_bit_cnt == BCW'(WORD_W - 1));

    // Auto mode pushes on the edge after word completion, i.e. whenever pending is seen.
    assign w_push_req = AUTO_ENQ ? r_pending : (r_pending & w_enq_press);
    assign w_drop     = w_push_req & w_full & ~(w_deq_press & ~w_empty);

    // Edge registers keep tracking through clear so a held level never fires on release.
    always_ff @(posedge clock_1MHz or negedge rst) begin
        if (!rst) begin
            r_write_q <= 1'b0;
            r_enq_q   <= 1'b0;
            r_deq_q   <= 1'b0;
        end else begin
            r_write_q <= bus.write_in;
            r_enq_q   <= bus.enqueue_in;
            r_deq_q   <= bus.dequeue_in;
        end
    end

    always_ff @(posedge clock_1MHz or negedge rst) begin
        if (!rst) begin
            r_sr       <= '0;
            r_bit_cnt  <= '0;
            r_hold     <= '0;
            r_pending  <= 1'b0;
            r_overflow <= 1'b0;
        end else if (bus.clear_in) begin
            r_bit_cnt  <= '0;
            r_pending  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_req) begin
                r_pending <= 1'b0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            // Writes stall while a completed word waits to be pushed.
            if (w_write_press && !r_pending) begin
                r_sr <= w_shift_next;
                if (w_last_bit) begin
                    r_bit_cnt <= '0;
                    r_hold    <= w_shift_next;
                    r_pending <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + BCW'(1);
                end
            end
        end
    end

    word_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clock_1MHz),
        .rst_n   (rst),
        .i_push  (w_push_req),
        .i_pop   (w_deq_press),
        .i_clear (bus.clear_in),
        .i_wdata (r_hold),
        .o_rdata (w_rdata),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.data_out     = w_rdata;
    assign bus.count_out    = w_count;
    assign bus.status_out   = ~w_full;
    assign bus.empty_out    = w_empty;
    assign bus.overflow_out = r_overflow;
endmodule

// File: tb/tb_serial_word_queue.sv
// tb/tb_serial_word_queue.sv - self-checking bench for serial_word_queue (two configurations)
`timescale 1ns/1ps
module tb_serial_word_queue;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // Instance 0: DEPTH=4, MSB first, auto enqueue. Instance 1: DEPTH=8, LSB first, explicit enqueue.
    serial_word_queue_if #(.WORD_W(8), .DEPTH(4)) ifa ();
    serial_word_queue_if #(.WORD_W(8), .DEPTH(8)) ifb ();

    serial_word_queue #(.WORD_W(8), .DEPTH(4), .MSB_FIRST(1'b1), .AUTO_ENQ(1'b1)) dut_a (
        .clock_1MHz (clk),
        .rst        (rst_n),
        .bus        (ifa.slave)
    );

    serial_word_queue #(.WORD_W(8), .DEPTH(8), .MSB_FIRST(1'b0), .AUTO_ENQ(1'b0)) dut_b (
        .clock_1MHz (clk),
        .rst        (rst_n),
        .bus        (ifb.slave)
    );

    initial clk = 1'b0;
    always #500 clk = ~clk;

    // Reference model state
    int         cfg_depth [2] = '{4, 8};
    bit         cfg_msb   [2] = '{1'b1, 1'b0};
    bit         cfg_auto  [2] = '{1'b1, 1'b0};
    int         m_bits    [2][8];
    int         m_bc      [2];
    bit         m_pend    [2];
    bit         m_ovf     [2];
    logic [7:0] m_hold    [2];
    logic [7:0] m_data    [2];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    task automatic nedge(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int sel, input logic d, input logic w, input logic e,
                         input logic q, input logic c);
        if (sel == 0) begin
            ifa.data_in = d; ifa.write_in = w; ifa.enqueue_in = e; ifa.dequeue_in = q; ifa.clear_in = c;
        end else begin
            ifb.data_in = d; ifb.write_in = w; ifb.enqueue_in = e; ifb.dequeue_in = q; ifb.clear_in = c;
        end
    endtask

    function automatic int m_size(input int sel);
        return (sel == 0) ? q0.size() : q1.size();
    endfunction

    task automatic m_reset_all();
        for (int s = 0; s < 2; s++) begin
            m_bc[s] = 0; m_pend[s] = 1'b0; m_ovf[s] = 1'b0; m_data[s] = 8'h00;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic m_clear(input int sel);
        m_bc[sel] = 0; m_pend[sel] = 1'b0; m_ovf[sel] = 1'b0;
        if (sel == 0) q0.delete(); else q1.delete();
    endtask

    task automatic m_push(input int sel);
        if (m_size(sel) < cfg_depth[sel]) begin
            if (sel == 0) q0.push_back(m_hold[0]); else q1.push_back(m_hold[1]);
        end else begin
            m_ovf[sel] = 1'b1;
        end
        m_pend[sel] = 1'b0;
    endtask

    task automatic m_pop(input int sel);
        if (m_size(sel) > 0) begin
            m_data[sel] = (sel == 0) ? q0.pop_front() : q1.pop_front();
        end
    endtask

    task automatic m_bit(input int sel, input int b);
        int w;
        if (m_pend[sel]) return;
        m_bits[sel][m_bc[sel]] = b;
        m_bc[sel]++;
        if (m_bc[sel] == 8) begin
            w = 0;
            for (int i = 0; i < 8; i++)
                w += m_bits[sel][i] * (cfg_msb[sel] ? (1 << (7 - i)) : (1 << i));
            m_hold[sel] = w[7:0];
            m_bc[sel] = 0;
            m_pend[sel] = 1'b1;
            if (cfg_auto[sel]) m_push(sel);
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input int sel, input string step);
        int d, c, e, s, o;
        if (sel == 0) begin
            d = int'(ifa.data_out); c = int'(ifa.count_out); e = int'(ifa.empty_out);
            s = int'(ifa.status_out); o = int'(ifa.overflow_out);
        end else begin
            d = int'(ifb.data_out); c = int'(ifb.count_out); e = int'(ifb.empty_out);
            s = int'(ifb.status_out); o = int'(ifb.overflow_out);
        end
        chk($sformatf("%s[%0d] data_out", step, sel), d, int'(m_data[sel]));
        chk($sformatf("%s[%0d] count_out", step, sel), c, m_size(sel));
        chk($sformatf("%s[%0d] empty_out", step, sel), e, int'(m_size(sel) == 0));
        chk($sformatf("%s[%0d] status_out", step, sel), s, int'(m_size(sel) != cfg_depth[sel]));
        chk($sformatf("%s[%0d] overflow_out", step, sel), o, int'(m_ovf[sel]));
    endtask

    task automatic write_bit(input int sel, input logic b, input int hold, input string step);
        drive(sel, b, 1'b1, 1'b0, 1'b0, 1'b0);
        nedge(hold);
        drive(sel, b, 1'b0, 1'b0, 1'b0, 1'b0);
        nedge(2);
        m_bit(sel, int'(b));
        check_state(sel, step);
    endtask

    task automatic send_word(input int sel, input logic [7:0] val, input int hold, input string step);
        for (int i = 0; i < 8; i++)
            write_bit(sel, cfg_msb[sel] ? val[7 - i] : val[i], hold, step);
    endtask

    task automatic enq(input int sel, input int hold, input string step);
        drive(sel, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        nedge(hold);
        drive(sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nedge(2);
        if (!cfg_auto[sel] && m_pend[sel]) m_push(sel);
        check_state(sel, step);
    endtask

    task automatic deq(input int sel, input int hold, input string step);
        drive(sel, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        nedge(hold);
        drive(sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nedge(2);
        m_pop(sel);
        check_state(sel, step);
    endtask

    task automatic clr(input int sel, input string step);
        drive(sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        nedge(1);
        drive(sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nedge(1);
        m_clear(sel);
        check_state(sel, step);
    endtask

    initial begin
        logic [7:0] lsb03;
        int         sel;
        int         op;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        m_reset_all();
        nedge(2);
        rst_n = 1'b1;
        nedge(1);
        check_state(0, "reset");
        check_state(1, "reset");

        // 1: single word 0x80, push lands one edge after the completing press edge
        for (int i = 0; i < 7; i++) write_bit(0, (i == 0) ? 1'b1 : 1'b0, 10, "t1_bits");
        drive(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        nedge(1);
        chk("t1 count_before_push", int'(ifa.count_out), 0);
        nedge(1);
        chk("t1 count_after_push", int'(ifa.count_out), 1);
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nedge(2);
        m_bit(0, 0);
        check_state(0, "t1_word");
        deq(0, 10, "t1_pop");
        chk("t1 data_80", int'(ifa.data_out), 8'h80);

        // 2: in-order pops, long held press pops once, pop on empty holds data
        send_word(0, 8'h80, 2, "t2_w");
        send_word(0, 8'h81, 2, "t2_w");
        send_word(0, 8'h82, 2, "t2_w");
        send_word(0, 8'h83, 2, "t2_w");
        deq(0, 200, "t2_pop_long");
        chk("t2 single_pop_per_press", int'(ifa.count_out), 3);
        deq(0, 5, "t2_pop");
        deq(0, 5, "t2_pop");
        deq(0, 5, "t2_pop");
        deq(0, 5, "t2_pop_empty");
        chk("t2 data_holds_83", int'(ifa.data_out), 8'h83);

        // 3: overflow on DEPTH=4
        for (int i = 1; i <= 5; i++) send_word(0, 8'(i), 1, "t3_fill");
        chk("t3 overflow_set", int'(ifa.overflow_out), 1);
        for (int i = 0; i < 4; i++) deq(0, 1, "t3_drain");
        chk("t3 last_word_4", int'(ifa.data_out), 4);

        // 4: full, push and pop share an edge
        clr(0, "t4_clr");
        for (int i = 0; i < 4; i++) send_word(0, 8'h11 + 8'(i), 1, "t4_fill");
        for (int i = 0; i < 7; i++) write_bit(0, 1'b0, 1, "t4_bits");
        drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        nedge(1);
        drive(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        nedge(1);
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nedge(2);
        m_pop(0);
        m_bit(0, 1);
        check_state(0, "t4_simul");
        chk("t4 no_overflow", int'(ifa.overflow_out), 0);

        // 5: explicit enqueue, LSB first
        enq(1, 2, "t5_enq_idle");
        lsb03 = 8'h03;
        send_word(1, lsb03, 2, "t5_bits");
        write_bit(1, 1'b1, 2, "t5_ignored");
        enq(1, 3, "t5_enq");
        deq(1, 3, "t5_pop");
        chk("t5 data_03", int'(ifb.data_out), 8'h03);

        // 6a: reset mid-word, then a clean word
        for (int i = 0; i < 5; i++) write_bit(0, 1'b1, 1, "t6_part");
        rst_n = 1'b0;
        nedge(1);
        m_reset_all();
        check_state(0, "t6_rst");
        check_state(1, "t6_rst");
        rst_n = 1'b1;
        nedge(1);
        send_word(0, 8'hA5, 1, "t6_word");
        deq(0, 1, "t6_pop");
        chk("t6 data_A5_after_rst", int'(ifa.data_out), 8'hA5);

        // 6b: clear mid-word with write held through the clear edge
        for (int i = 0; i < 5; i++) write_bit(0, 1'b1, 1, "t6_part2");
        drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        nedge(1);
        drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        nedge(2);
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nedge(2);
        m_clear(0);
        check_state(0, "t6_clr");
        send_word(0, 8'hA5, 1, "t6_word2");
        deq(0, 1, "t6_pop2");
        chk("t6 data_A5_after_clr", int'(ifa.data_out), 8'hA5);

        // Randomized traffic on both instances
        for (int n = 0; n < 600; n++) begin
            sel = int'($urandom_range(0, 1));
            op  = int'($urandom_range(0, 39));
            if (op == 0)       clr(sel, "rnd_clr");
            else if (op < 24)  write_bit(sel, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)), "rnd_bit");
            else if (op < 31)  enq(sel, int'($urandom_range(1, 3)), "rnd_enq");
            else               deq(sel, int'($urandom_range(1, 3)), "rnd_deq");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
